// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit byte-addressed memory port between instruction fetch and load/store
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LOAD_CYCLES = 2,
  parameter int MAX_STREAK  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rsp_valid,
  output logic [15:0]           if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rsp_valid,
  output logic [15:0]           d_rdata,
  output logic                  d_err,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data_in,
  input  logic [15:0]           mem_data_out,
  output logic                  mem_rst,
  output logic                  busy
);
  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int CW = $clog2(LOAD_CYCLES + 1);
  localparam int SW = $clog2(MAX_STREAK + 1);

  logic [0:0]            state;
  logic [CW-1:0]         cnt;
  logic [SW-1:0]         streak;
  logic                  run;
  logic [ADDR_WIDTH-1:0] gnt_addr;

  assign run      = state == RUN;
  assign busy     = ~run;
  assign mem_rst  = ~run;
  // D normally wins a tie; IF is forced once D has won MAX_STREAK times in a row while IF waited
  assign d_gnt    = run & d_req & ~(if_req & streak == SW'(MAX_STREAK));
  assign if_gnt   = run & if_req & ~d_gnt;
  assign gnt_addr = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
  // odd addresses are granted but never reach the memory
  assign mem_enable  = (d_gnt | if_gnt) & ~gnt_addr[0];
  assign mem_addr    = mem_enable ? gnt_addr : '0;
  assign mem_wr      = mem_enable & d_gnt & d_wr;
  assign mem_data_in = (mem_enable & d_gnt) ? d_wdata : '0;

  // hold the memory in its image-load window for LOAD_CYCLES cycles after reset, then run forever
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
      cnt   <= '0;
    end else if (!run) begin
      cnt <= cnt + 1'b1;
      if (cnt == CW'(LOAD_CYCLES - 1)) state <= RUN;
    end
  end

  // count consecutive D wins while IF waits; saturate so IF gets the next slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) streak <= '0;
    else if (!if_req || if_gnt) streak <= '0;
    else if (d_gnt && streak != SW'(MAX_STREAK)) streak <= streak + 1'b1;
  end

  // register the response of this cycle's winner; stores and misaligned accesses return zero data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rsp_valid <= 1'b0;
      if_err       <= 1'b0;
      if_rdata     <= '0;
      d_rsp_valid  <= 1'b0;
      d_err        <= 1'b0;
      d_rdata      <= '0;
    end else begin
      if_rsp_valid <= if_gnt;
      if_err       <= if_gnt & if_addr[0];
      if_rdata     <= (if_gnt & ~if_addr[0]) ? mem_data_out : '0;
      d_rsp_valid  <= d_gnt;
      d_err        <= d_gnt & d_addr[0];
      d_rdata      <= (d_gnt & ~d_addr[0] & ~d_wr) ? mem_data_out : '0;
    end
  end
endmodule
